param_ffram: RTL

//  Parametrised 1W/1R flip-flop RAM with per-lane (byte) write enables and a

---
 rtl/param_ffram.sv | 124 ++++++++++++
 1 files changed

// File: rtl/param_ffram.sv
// param_ffram: parametrised 1W/1R flip-flop RAM with per-lane write enables,
// a registered read port and write-first read-during-write bypass.
// Optional post-reset clear sequencer, enabled by defining PARAM_FFRAM_CLEAR_EN.
// Without the macro there is no sequencer and the RAM is usable immediately.
module param_ffram #(
  parameter int DATA_W = 41,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  localparam int NL    = DATA_W / LANE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              ready_o,
  input  logic [NL-1:0]     wen_i,
  input  logic [ADDR_W-1:0] wadr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] radr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              rvalid_o
);

  localparam logic [31:0] DEPTH_U = DEPTH;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_data;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              rd_hit;
  logic              clr_active;
  logic [ADDR_W-1:0] clr_cnt;

  // Expand lane enables to one enable per bit; the top lane absorbs the
  // leftover bits when DATA_W is not a multiple of LANE_W.
  for (genvar b = 0; b < DATA_W; b++) begin : g_mask
    localparam int LANE = ((b / LANE_W) < NL) ? (b / LANE_W) : (NL - 1);
    assign bit_mask[b] = wen_i[LANE];
  end

  // Out-of-range addresses never touch storage (DEPTH need not be 2**ADDR_W).
  assign wr_in_range = 32'(wadr_i) < DEPTH_U;
  assign rd_in_range = 32'(radr_i) < DEPTH_U;
  assign rd_hit      = wr_in_range && (wadr_i == radr_i);

  assign rd_word = rd_in_range ? mem[radr_i] : '0;
  assign wr_word = (mem[wadr_i] & ~bit_mask) | (data_i & bit_mask);

  // Write-first: on an address collision the enabled lanes come from data_i.
  assign rd_data = rd_hit ? ((rd_word & ~bit_mask) | (data_i & bit_mask)) : rd_word;

`ifdef PARAM_FFRAM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_nx;

  // Sequencer state register; reset always restarts the sweep at address 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_nx;
    end
  end

  // Sweep one word per cycle; leave CLEAR after the last word is written.
  always_comb begin
    state_nx = state;
    clr_nx   = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_nx = clr_cnt + ADDR_W'(1);
        if (32'(clr_cnt) == (DEPTH_U - 32'd1)) begin
          state_nx = ST_READY;
          clr_nx   = '0;
        end
      end
      ST_READY: begin
        state_nx = ST_READY;
      end
    endcase
  end

  assign clr_active = (state == ST_CLEAR);
  assign ready_o    = (state == ST_READY);
`else
  assign clr_active = 1'b0;
  assign clr_cnt    = '0;
  assign ready_o    = 1'b1;
`endif

  // Storage update: the clear sweep has priority and user writes are ignored
  // while it runs; reset itself leaves the contents alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clr_active) begin
        mem[clr_cnt] <= '0;
      end else if (wr_in_range && (|wen_i)) begin
        mem[wadr_i] <= wr_word;
      end
    end
  end

  // Registered read port; data_o holds its value when no read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o   <= '0;
      rvalid_o <= 1'b0;
    end else if (ready_o && ren_i) begin
      data_o   <= rd_data;
      rvalid_o <= 1'b1;
    end else begin
      rvalid_o <= 1'b0;
    end
  end

endmodule
